multi_cycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS CPU inside `top_for_multy_CPU`. It sequences the shared datapath: one memory, one ALU, the IR, PC and register file. Each instruction runs as a series of one-clock steps, and the FSM drives every datapath enable and mux select in each step. Memory steps wait on a ready handshake. The current state is exported for the board's debug display.

---
 rtl/multi_cycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath, with a memory-wait watchdog.
// Define MULTI_CTRL_JAL_EN to build in the jal (opcode 000011) dispatch and JAL state.
module multi_cycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTI_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11
`ifdef MULTI_CTRL_JAL_EN
    , S_JAL = 4'd12
`endif
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            timeout_reg, timeout_next;
  logic            is_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IF;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    timeout_next  = timeout_reg;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    illegal       = 1'b0;

    case (state_reg)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_next = S_ID;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     state_next = S_REX;
          OP_LW, OP_SW: state_next = S_MADR;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JMP;
          OP_ADDI:      state_next = S_IEX;
`ifdef MULTI_CTRL_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default: begin
            state_next = S_IF;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is stable until the next fetch, so the opcode still tells lw from sw
        if (opcode == OP_SW) state_next = S_MWR;
        else if (opcode == OP_LW) state_next = S_MRD;
        else state_next = S_IF;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_next = S_MWB;
      end
      S_MWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        state_next = S_IF;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_next = S_IF;
      end
      S_REX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        state_next = S_IF;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_next  = S_IF;
      end
      S_JMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        state_next = S_IF;
      end
      S_IEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        state_next = S_IF;
      end
`ifdef MULTI_CTRL_JAL_EN
      S_JAL: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        state_next = S_IF;
      end
`endif
      default: state_next = S_IF;
    endcase

    // Watchdog: any non-waiting cycle (ready or a different state) restarts the count
    is_wait = ((state_reg == S_IF) || (state_reg == S_MRD) || (state_reg == S_MWR)) && !mem_ready;
    if (is_wait) begin
      if ((int'(wait_cnt_reg) + 1) >= MEM_WAIT_MAX) begin
        timeout_next = 1'b1;
        state_next   = S_IF;
      end else begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end

    // Reset aborts the instruction at once, so no enable may leak through
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal     = 1'b0;
    end
  end

  assign state       = state_reg;
  assign mem_timeout = timeout_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl against an instruction-level model.
// Honours MULTI_CTRL_JAL_EN the same way the design does.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
  logic       illegal, mem_timeout;
  logic [3:0] state;
  logic [18:0] ctrl;

  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_st[$];
  logic        exp_rdy[$];
  logic [5:0]  exp_op[$];
  logic [3:0]  obs_st[$];
  logic [18:0] obs_ctrl[$];
  logic [3:0]  end_st;

  multi_cycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                 RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, illegal};

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08: return 1'b1;
`ifdef MULTI_CTRL_JAL_EN
      6'h03: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Control word each step must present, straight from the per-step action list
  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, rw, srca, ill;
    logic [1:0] rdst, m2r, srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, rw, srca, ill} = '0;
    {rdst, m2r, srcb, aop, psrc} = '0;
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  begin srcb = 2'b11; ill = !is_legal(op); end
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin srca = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 2'b01; end
      4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      4'd9:  begin pcw = 1; psrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: begin rw = 1; end
      4'd12: begin pcw = 1; psrc = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, rw, srca, rdst, m2r, srcb, aop, psrc, ill};
  endfunction

  task automatic push_cyc(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    exp_st.push_back(st);
    exp_rdy.push_back(rdy);
    exp_op.push_back(op);
  endtask

  // Instruction-level model: step list for one instruction with given memory waits
  task automatic model_instr(input logic [5:0] op, input int if_wait, input int mem_wait);
    for (int k = 0; k < if_wait; k++) push_cyc(4'd0, 1'b0, op);
    push_cyc(4'd0, 1'b1, op);
    push_cyc(4'd1, 1'($urandom), op);
    case (op)
      6'h23: begin
        push_cyc(4'd2, 1'($urandom), op);
        for (int k = 0; k < mem_wait; k++) push_cyc(4'd3, 1'b0, op);
        push_cyc(4'd3, 1'b1, op);
        push_cyc(4'd4, 1'($urandom), op);
      end
      6'h2b: begin
        push_cyc(4'd2, 1'($urandom), op);
        for (int k = 0; k < mem_wait; k++) push_cyc(4'd5, 1'b0, op);
        push_cyc(4'd5, 1'b1, op);
      end
      6'h00: begin push_cyc(4'd6, 1'($urandom), op); push_cyc(4'd7, 1'($urandom), op); end
      6'h08: begin push_cyc(4'd10, 1'($urandom), op); push_cyc(4'd11, 1'($urandom), op); end
      6'h04: push_cyc(4'd8, 1'($urandom), op);
      6'h02: push_cyc(4'd9, 1'($urandom), op);
`ifdef MULTI_CTRL_JAL_EN
      6'h03: push_cyc(4'd12, 1'($urandom), op);
`endif
      default: ;
    endcase
  endtask

  task automatic clear_q();
    exp_st.delete(); exp_rdy.delete(); exp_op.delete();
  endtask

  // Drives the modelled steps one per clock and records what the DUT shows
  task automatic play();
    obs_st.delete(); obs_ctrl.delete();
    foreach (exp_st[i]) begin
      mem_ready = exp_rdy[i];
      opcode    = exp_op[i];
      #1;
      obs_st.push_back(state);
      obs_ctrl.push_back(ctrl);
      @(negedge clk);
    end
    #1;
    end_st = state;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got %0b want 0", mem_timeout); end
    total++;
    if (ctrl !== 19'd0) begin bad++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
    rst = 1'b0;
    #1;
    total++;
    if (ctrl !== exp_ctrl(4'd0, 1'b1, 6'h23)) begin
      bad++; $display("FAIL reset_release_ctrl got %h want %h", ctrl, exp_ctrl(4'd0, 1'b1, 6'h23));
    end
    $display("reset: state=%0d mem_timeout=%0b ctrl=%h", state, mem_timeout, ctrl);
  endtask

  task automatic test_lw_sw();
    clear_q();
    model_instr(6'h23, 0, 0);
    model_instr(6'h2b, 2, 3);
    play();
    foreach (exp_st[i]) begin
      total++;
      if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL lw_sw state cyc %0d got %0d want %0d", i, obs_st[i], exp_st[i]); end
      total++;
      if (obs_ctrl[i] !== exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i])) begin
        bad++; $display("FAIL lw_sw ctrl cyc %0d got %h want %h", i, obs_ctrl[i], exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i]));
      end
    end
    total++;
    if (end_st !== 4'd0) begin bad++; $display("FAIL lw_sw end_state got %0d want 0", end_st); end
    $display("lw+sw(wait 3): %0d cycles checked", exp_st.size());
  endtask

  task automatic test_branch_jump();
    clear_q();
    model_instr(6'h04, 0, 0);
    model_instr(6'h02, 1, 0);
    model_instr(6'h00, 0, 0);
    model_instr(6'h08, 0, 0);
    play();
    foreach (exp_st[i]) begin
      total++;
      if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL br_j state cyc %0d got %0d want %0d", i, obs_st[i], exp_st[i]); end
      total++;
      if (obs_ctrl[i] !== exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i])) begin
        bad++; $display("FAIL br_j ctrl cyc %0d got %h want %h", i, obs_ctrl[i], exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i]));
      end
    end
    total++;
    if (end_st !== 4'd0) begin bad++; $display("FAIL br_j end_state got %0d want 0", end_st); end
    $display("beq+j+rtype+addi: %0d cycles checked", exp_st.size());
  endtask

  task automatic test_illegal_jal();
    clear_q();
    model_instr(6'h3f, 0, 0);
    model_instr(6'h03, 0, 0);
    play();
    foreach (exp_st[i]) begin
      total++;
      if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL ill_jal state cyc %0d got %0d want %0d", i, obs_st[i], exp_st[i]); end
      total++;
      if (obs_ctrl[i] !== exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i])) begin
        bad++; $display("FAIL ill_jal ctrl cyc %0d got %h want %h", i, obs_ctrl[i], exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i]));
      end
    end
    total++;
    if (end_st !== 4'd0) begin bad++; $display("FAIL ill_jal end_state got %0d want 0", end_st); end
    $display("illegal 111111 + jal: %0d cycles checked", exp_st.size());
  endtask

  task automatic test_random();
    logic [5:0] ops [0:6];
    logic [5:0] op;
    ops[0] = 6'h23; ops[1] = 6'h2b; ops[2] = 6'h00; ops[3] = 6'h04;
    ops[4] = 6'h02; ops[5] = 6'h08; ops[6] = 6'h03;
    for (int n = 0; n < 150; n++) begin
      clear_q();
      if ($urandom_range(0, 7) == 7) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      model_instr(op, $urandom_range(0, 4), $urandom_range(0, 4));
      play();
      foreach (exp_st[i]) begin
        total++;
        if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL rand%0d state cyc %0d got %0d want %0d", n, i, obs_st[i], exp_st[i]); end
        total++;
        if (obs_ctrl[i] !== exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i])) begin
          bad++; $display("FAIL rand%0d ctrl cyc %0d got %h want %h", n, i, obs_ctrl[i], exp_ctrl(exp_st[i], exp_rdy[i], exp_op[i]));
        end
      end
      total++;
      if (end_st !== 4'd0) begin bad++; $display("FAIL rand%0d end_state got %0d want 0", n, end_st); end
      $display("rand %0d: op=%b cycles=%0d", n, op, exp_st.size());
    end
  endtask

  task automatic test_timeout();
    // IF starved for the full limit
    mem_ready = 1'b0; opcode = 6'h23;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      total++;
      if (mem_timeout !== (k == 15)) begin bad++; $display("FAIL if_timeout k=%0d got %0b want %0b", k, mem_timeout, k == 15); end
      total++;
      if (state !== 4'd0) begin bad++; $display("FAIL if_timeout_state k=%0d got %0d want 0", k, state); end
    end
    $display("if timeout: mem_timeout=%0b state=%0d", mem_timeout, state);
    // flag survives a normal instruction
    clear_q();
    model_instr(6'h00, 0, 0);
    play();
    total++;
    if (mem_timeout !== 1'b1 || end_st !== 4'd0) begin
      bad++; $display("FAIL timeout_sticky got flag=%0b state=%0d want flag=1 state=0", mem_timeout, end_st);
    end
    // lw starved in MRD
    opcode = 6'h23; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 4'd3) begin bad++; $display("FAIL mrd_enter got %0d want 3", state); end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      total++;
      if (state !== ((k == 15) ? 4'd0 : 4'd3)) begin
        bad++; $display("FAIL mrd_timeout k=%0d got %0d want %0d", k, state, (k == 15) ? 0 : 3);
      end
    end
    $display("mrd timeout: state=%0d mem_timeout=%0b", state, mem_timeout);
    rst = 1'b1;
    #1;
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got %0b want 0", mem_timeout); end
    rst = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    opcode = 6'h2b; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      bad++; $display("FAIL mwr_enter got state=%0d MemWrite=%0b want 5/1", state, MemWrite);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (MemWrite !== 1'b0 || state !== 4'd0) begin
      bad++; $display("FAIL rst_mid got MemWrite=%0b state=%0d want 0/0", MemWrite, state);
    end
    total++;
    if (ctrl !== 19'd0) begin bad++; $display("FAIL rst_mid_ctrl got %h want 0", ctrl); end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    total++;
    if (ctrl !== exp_ctrl(4'd0, 1'b1, 6'h2b) || state !== 4'd0) begin
      bad++; $display("FAIL rst_mid_release got %h state=%0d want %h state=0", ctrl, state, exp_ctrl(4'd0, 1'b1, 6'h2b));
    end
    $display("reset mid-MWR: state=%0d MemWrite=%0b", state, MemWrite);
  endtask

  initial begin
    test_reset();
    test_lw_sw();
    test_branch_jump();
    test_illegal_jal();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL time_limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
